pet_stats_engine: RTL and testbench
===================================

PET_STATS_ENGINE -- requirements
Module: pet_stats_engine

Interface
REQ-001 SHALL have parameter NUM_STATS, default 4: number of stat channels, range 2..8.
REQ-002 SHALL have parameter STAT_W, default 5: width of each stat counter.
REQ-003 SHALL have parameter STAT_MAX, default 15: saturation and death value, less than 2^STAT_W.
REQ-004 SHALL have parameter TICK_DIV, default 27000000: clk cycles per tick, at least 2.
REQ-005 SHALL have parameter ENERGY_IDX, default 3: index of the stat drained during sleep.
REQ-006 SHALL have parameter CMD_CODES, 8*NUM_STATS bits, default {8'h00,8'h62,8'h70,8'h65}: byte k is the care command that decrements stat k; 8'h00 disables that slot.
REQ-007 SHALL have ports: clk in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: inputs in 8, command byte, 8'h00 = idle; random in 8, pseudo-random value.
REQ-009 SHALL have ports: stats out NUM_STATS*STAT_W, packed stat values, stat k at bits [k*STAT_W +: STAT_W].
REQ-010 SHALL have ports: second out 1, toggles each tick; is_sleeping out 1; is_dead out 1; cmd_ack out 1, one-cycle pulse per accepted command.

Function
REQ-011 SHALL run a tick counter 0..TICK_DIV-1 in every state; tick asserts for the one cycle when the count equals TICK_DIV-1, and the count then wraps to 0.
REQ-012 SHALL toggle second on every tick.
REQ-013 SHALL implement states AWAKE, SLEEPING, DEAD; is_sleeping = (SLEEPING), is_dead = (DEAD).
REQ-014 SHALL arm command acceptance only when inputs == 8'h00; accept at most one command per arming, so a held byte acts once; an unrecognised non-zero byte leaves acceptance armed.
REQ-015 SHALL, in AWAKE, on an armed byte equal to CMD_CODES[k] (non-zero): decrement stat k, saturating at 0; pulse cmd_ack; disarm. Lowest k wins on duplicate codes.
REQ-016 SHALL, in AWAKE, on armed 8'h73 ('s'): go to SLEEPING, pulse cmd_ack, disarm.
REQ-017 SHALL, in SLEEPING, on 8'h77 ('w'): go to AWAKE regardless of arming, with no cmd_ack; all other bytes are ignored.
REQ-018 SHALL, in SLEEPING, on each tick where second == 1 before the toggle (every second tick): decrement stat ENERGY_IDX, saturating at 0.
REQ-019 SHALL, in SLEEPING, move to AWAKE on the cycle after stat ENERGY_IDX is 0 (auto-wake).
REQ-020 SHALL, on each tick in AWAKE or SLEEPING, let j = random[2:0] and, if j < NUM_STATS, increment stat j, saturating at STAT_MAX.
REQ-021 SHALL, when increment and decrement hit the same stat in one cycle, leave that stat unchanged; if the stat is 0 it becomes 1 only when the decrement saturated.
REQ-022 SHALL enter DEAD on the cycle after any stat equals STAT_MAX, from AWAKE or SLEEPING; this takes priority over the wake, sleep and command transitions of that cycle.
REQ-023 SHALL, in DEAD, freeze all stats and ignore all commands except armed 8'h72 ('r').
REQ-024 SHALL, on 'r' in DEAD: clear all stats to 0, go to AWAKE, pulse cmd_ack.
REQ-025 SHALL keep second and the tick counter running in DEAD.
REQ-026 SHALL drive all outputs from registers.

Reset
REQ-027 SHALL, while reset_n = 0, asynchronously set: all stats 0, state AWAKE, tick counter 0, second 0, cmd_ack 0, acceptance disarmed.
REQ-028 SHALL apply the reset of REQ-027 mid-operation in any state, including DEAD and SLEEPING, with no residual state.
REQ-029 SHALL require inputs == 8'h00 after reset before the first command is accepted.

Verification (TICK_DIV=4, defaults otherwise)
REQ-030 SHALL cover saturating care: stat0=3, inputs 8'h65 held 10 cycles, then 8'h00, then 8'h65 -> stat0=2 then 1; exactly two cmd_ack pulses.
REQ-031 SHALL cover tick increment: random=8'h01 for 3 ticks -> stat1=3, second toggled 3 times; random=8'h07 -> no stat changes.
REQ-032 SHALL cover sleep drain: energy=4, 's' -> is_sleeping=1; energy decrements every 8 cycles, reaches 0, is_sleeping=0 one cycle later; with random=8'h03 on drain ticks, energy stays unchanged.
REQ-033 SHALL cover death/revive: stat2=14, random=8'h02 tick -> stat2=15, is_dead=1 next cycle; 'p' ignored, stats frozen; 'r' -> all stats 0, is_dead=0, cmd_ack=1.
REQ-034 SHALL cover collision: stat0=5, random=8'h00 tick in the same cycle as accepted 8'h65 -> stat0=5, cmd_ack=1.
REQ-035 SHALL cover reset mid-sleep: SLEEPING, energy=7, reset_n low 1 cycle -> AWAKE, stats 0, second=0; 8'h65 held across release is ignored until 8'h00 is seen.

Source files
------------

// File: rtl/pet_stats_engine.sv
// Virtual-pet stat engine.
// Keeps NUM_STATS saturating counters. Random per-tick increments raise them, and care
// commands or sleep drain lower them. The pet dies when any counter reaches STAT_MAX.
module pet_stats_engine #(
    parameter int unsigned NUM_STATS  = 4,
    parameter int unsigned STAT_W     = 5,
    parameter int unsigned STAT_MAX   = 15,
    parameter int unsigned TICK_DIV   = 27000000,
    parameter int unsigned ENERGY_IDX = 3,
    parameter logic [8*NUM_STATS-1:0] CMD_CODES = {8'h00, 8'h62, 8'h70, 8'h65}
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    inputs,
    input  logic [7:0]                    random,
    output logic [NUM_STATS*STAT_W-1:0]   stats,
    output logic                          second,
    output logic                          is_sleeping,
    output logic                          is_dead,
    output logic                          cmd_ack
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0]   TickLast  = CntW'(TICK_DIV - 1);
    localparam logic [STAT_W-1:0] StatMaxV  = STAT_W'(STAT_MAX);
    localparam logic [7:0]        CmdSleep  = 8'h73;
    localparam logic [7:0]        CmdWake   = 8'h77;
    localparam logic [7:0]        CmdRevive = 8'h72;

    typedef enum logic [1:0] {
        StAwake,
        StSleep,
        StDead
    } state_e;

    // Tick generation
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            second_q;
    logic            tick;

    // Control state
    state_e state_q, state_d;
    logic   armed_q, armed_d;
    logic   ack_q;
    logic   sleep_q;
    logic   dead_q;

    // Stat storage
    logic [STAT_W-1:0] stat_q [NUM_STATS];
    logic [STAT_W-1:0] stat_d [NUM_STATS];

    // Decoded events for the current cycle
    logic       cmd_hit;
    logic [2:0] cmd_idx;
    logic       any_max;
    logic       dying;
    logic       accept_cmd;
    logic       accept_sleep;
    logic       wake;
    logic       revive;
    logic       drain;
    logic       bump;

    // Match the command byte against the care-code table; lowest index wins on duplicates.
    always_comb begin
        cmd_hit = 1'b0;
        cmd_idx = '0;
        for (int k = int'(NUM_STATS) - 1; k >= 0; k--) begin
            if (CMD_CODES[8*k +: 8] != 8'h00 && inputs == CMD_CODES[8*k +: 8]) begin
                cmd_hit = 1'b1;
                cmd_idx = 3'(k);
            end
        end
        any_max = 1'b0;
        for (int k = 0; k < int'(NUM_STATS); k++) begin
            if (stat_q[k] == StatMaxV) begin
                any_max = 1'b1;
            end
        end
    end

    // Next-state and event qualification. A pending death blocks every other action in
    // the same cycle, so the pet freezes on the exact values that killed it.
    always_comb begin
        tick  = (cnt_q == TickLast);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);

        dying        = any_max && (state_q != StDead);
        accept_cmd   = (state_q == StAwake) && !dying && armed_q && cmd_hit;
        accept_sleep = (state_q == StAwake) && !dying && armed_q && !cmd_hit &&
                       (inputs == CmdSleep);
        wake         = (state_q == StSleep) && !dying &&
                       ((inputs == CmdWake) || (stat_q[ENERGY_IDX] == '0));
        revive       = (state_q == StDead) && armed_q && (inputs == CmdRevive);
        drain        = (state_q == StSleep) && !dying && tick && second_q;
        bump         = (state_q != StDead) && !dying && tick;

        state_d = state_q;
        unique case (state_q)
            StAwake: begin
                if (dying) begin
                    state_d = StDead;
                end else if (accept_sleep) begin
                    state_d = StSleep;
                end
            end
            StSleep: begin
                if (dying) begin
                    state_d = StDead;
                end else if (wake) begin
                    state_d = StAwake;
                end
            end
            StDead: begin
                if (revive) begin
                    state_d = StAwake;
                end
            end
            default: state_d = StAwake;
        endcase

        // An idle byte re-arms; any accepted command consumes the arming.
        if (inputs == 8'h00) begin
            armed_d = 1'b1;
        end else if (accept_cmd || accept_sleep || revive) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // Per-stat update: decrement first, then increment, both saturating, which gives
    // "unchanged" on a collision except that 0 climbs to 1.
    always_comb begin
        for (int j = 0; j < int'(NUM_STATS); j++) begin
            stat_d[j] = stat_q[j];
            if (revive) begin
                stat_d[j] = '0;
            end else begin
                if (((accept_cmd && cmd_idx == 3'(j)) || (drain && j == int'(ENERGY_IDX))) &&
                    stat_d[j] != '0) begin
                    stat_d[j] = stat_d[j] - STAT_W'(1);
                end
                if (bump && random[2:0] == 3'(j) && stat_d[j] != StatMaxV) begin
                    stat_d[j] = stat_d[j] + STAT_W'(1);
                end
            end
        end
    end

    // Free-running tick counter and the second toggle; these never stop, even when dead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            second_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            second_q <= second_q ^ tick;
        end
    end

    // State machine with registered status flags and acknowledge pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StAwake;
            armed_q <= 1'b0;
            ack_q   <= 1'b0;
            sleep_q <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            ack_q   <= accept_cmd || accept_sleep || revive;
            sleep_q <= (state_d == StSleep);
            dead_q  <= (state_d == StDead);
        end
    end

    // Stat registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < int'(NUM_STATS); j++) begin
                stat_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NUM_STATS); j++) begin
                stat_q[j] <= stat_d[j];
            end
        end
    end

    // Pack the stat registers onto the output bus.
    always_comb begin
        stats = '0;
        for (int j = 0; j < int'(NUM_STATS); j++) begin
            stats[j*STAT_W +: STAT_W] = stat_q[j];
        end
    end

    assign second      = second_q;
    assign is_sleeping = sleep_q;
    assign is_dead     = dead_q;
    assign cmd_ack     = ack_q;

endmodule

// File: tb/tb_pet_stats_engine.sv
// Bench for pet_stats_engine: directed scenarios followed by a long random run, every cycle
// compared against a behavioural model of the pet.
module tb_pet_stats_engine;

    localparam int NS   = 4;
    localparam int SW   = 5;
    localparam int SMAX = 15;
    localparam int TD   = 4;
    localparam int EI   = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [7:0]       inputs = 8'h00;
    logic [7:0]       random = 8'h00;
    logic [NS*SW-1:0] stats;
    logic             second;
    logic             is_sleeping;
    logic             is_dead;
    logic             cmd_ack;

    pet_stats_engine #(
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .inputs      (inputs),
        .random      (random),
        .stats       (stats),
        .second      (second),
        .is_sleeping (is_sleeping),
        .is_dead     (is_dead),
        .cmd_ack     (cmd_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ack_seen = 0;

    // Behavioural model: mode 0 awake, 1 sleeping, 2 dead.
    int         m_stat [NS];
    int         m_cnt;
    bit         m_second;
    int         m_mode;
    bit         m_armed;
    bit         m_ack;
    logic [7:0] codes [NS] = '{8'h65, 8'h70, 8'h62, 8'h00};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dut_stat(input int k);
        return int'(stats[k*SW +: SW]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NS; k++) m_stat[k] = 0;
        m_cnt    = 0;
        m_second = 0;
        m_mode   = 0;
        m_armed  = 0;
        m_ack    = 0;
    endtask

    // Advance the model by one clock given the byte and random value seen at that edge.
    task automatic model_step(input logic [7:0] in, input logic [7:0] rnd);
        bit tick;
        bit dying;
        bit ack;
        int dec_k;
        int inc_k;
        int nmode;
        tick  = (m_cnt == TD - 1);
        dying = 0;
        ack   = 0;
        dec_k = -1;
        inc_k = -1;
        nmode = m_mode;
        for (int k = 0; k < NS; k++) if (m_stat[k] == SMAX && m_mode != 2) dying = 1;
        if (m_mode == 2) begin
            if (m_armed && in == 8'h72) begin
                for (int k = 0; k < NS; k++) m_stat[k] = 0;
                nmode = 0;
                ack   = 1;
            end
        end else if (dying) begin
            nmode = 2;
        end else begin
            if (m_mode == 0) begin
                if (m_armed && in != 8'h00) begin
                    for (int k = NS - 1; k >= 0; k--) if (codes[k] == in) dec_k = k;
                    if (dec_k >= 0) ack = 1;
                    else if (in == 8'h73) begin
                        nmode = 1;
                        ack   = 1;
                    end
                end
            end else begin
                if (in == 8'h77 || m_stat[EI] == 0) nmode = 0;
                if (tick && m_second) dec_k = EI;
            end
            if (tick && int'(rnd[2:0]) < NS) inc_k = int'(rnd[2:0]);
            if (dec_k >= 0 && m_stat[dec_k] > 0) m_stat[dec_k] = m_stat[dec_k] - 1;
            if (inc_k >= 0 && m_stat[inc_k] < SMAX) m_stat[inc_k] = m_stat[inc_k] + 1;
        end
        if (in == 8'h00) m_armed = 1;
        else if (ack) m_armed = 0;
        if (tick) m_second = !m_second;
        m_cnt  = (m_cnt + 1) % TD;
        m_mode = nmode;
        m_ack  = ack;
    endtask

    task automatic check_all();
        for (int k = 0; k < NS; k++) check_eq($sformatf("stat%0d", k), dut_stat(k), m_stat[k]);
        check_eq("second", int'(second), int'(m_second));
        check_eq("is_sleeping", int'(is_sleeping), int'(m_mode == 1));
        check_eq("is_dead", int'(is_dead), int'(m_mode == 2));
        check_eq("cmd_ack", int'(cmd_ack), int'(m_ack));
    endtask

    // Drive one cycle from a negedge, then check at the following negedge.
    task automatic cycle(input logic [7:0] in, input logic [7:0] rnd);
        inputs = in;
        random = rnd;
        model_step(in, rnd);
        @(negedge clk);
        check_all();
        if (cmd_ack) ack_seen++;
    endtask

    // One-cycle reset pulse applied from a negedge, with a byte held across it.
    task automatic do_reset(input logic [7:0] in);
        reset_n = 1'b0;
        inputs  = in;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
    endtask

    logic [7:0] cur_in;
    int         pick;

    initial begin
        repeat (2) @(negedge clk);
        model_reset();
        check_all();
        reset_n = 1'b1;

        // Random index 1 on three ticks, then an out-of-range index.
        repeat (12) cycle(8'h00, 8'h01);
        check_eq("tick_stat1", dut_stat(1), 3);
        check_eq("tick_second", int'(second), 1);
        repeat (8) cycle(8'h00, 8'h07);
        check_eq("idx7_stat1", dut_stat(1), 3);
        check_eq("idx7_others", dut_stat(0) + dut_stat(2) + dut_stat(3), 0);

        // Held care byte acts once per arming.
        repeat (12) cycle(8'h00, 8'h00);
        check_eq("care_pre", dut_stat(0), 3);
        ack_seen = 0;
        repeat (10) cycle(8'h65, 8'h07);
        check_eq("care_held", dut_stat(0), 2);
        cycle(8'h00, 8'h07);
        repeat (2) cycle(8'h65, 8'h07);
        check_eq("care_again", dut_stat(0), 1);
        check_eq("care_acks", ack_seen, 2);

        // Sleep drains energy down to zero, then auto-wakes.
        repeat (16) cycle(8'h00, 8'h03);
        check_eq("energy_pre", dut_stat(EI), 4);
        cycle(8'h73, 8'h07);
        check_eq("sleep_entered", int'(is_sleeping), 1);
        repeat (40) cycle(8'h00, 8'h07);
        check_eq("drain_energy", dut_stat(EI), 0);
        check_eq("auto_wake", int'(is_sleeping), 0);

        // Death, frozen stats, revive.
        repeat (64) cycle(8'h00, 8'h02);
        check_eq("death_stat2", dut_stat(2), 15);
        check_eq("death_flag", int'(is_dead), 1);
        cycle(8'h00, 8'h07);
        repeat (2) cycle(8'h70, 8'h07);
        check_eq("dead_frozen", dut_stat(1), 3);
        cycle(8'h00, 8'h07);
        cycle(8'h72, 8'h07);
        check_eq("revive_ack", int'(cmd_ack), 1);
        check_eq("revive_alive", int'(is_dead), 0);
        check_eq("revive_stat2", dut_stat(2), 0);

        // Increment and decrement of stat0 in the same cycle.
        repeat (20) cycle(8'h00, 8'h00);
        check_eq("coll_pre", dut_stat(0), 5);
        for (int i = 0; i < TD && m_cnt != TD - 1; i++) cycle(8'h00, 8'h07);
        cycle(8'h65, 8'h00);
        check_eq("coll_stat0", dut_stat(0), 5);
        check_eq("coll_ack", int'(cmd_ack), 1);

        // Reset while asleep, care byte held across release.
        repeat (28) cycle(8'h00, 8'h03);
        cycle(8'h00, 8'h07);
        cycle(8'h73, 8'h07);
        check_eq("rst_sleep_pre", int'(is_sleeping), 1);
        do_reset(8'h65);
        check_eq("rst_awake", int'(is_sleeping), 0);
        check_eq("rst_second", int'(second), 0);
        check_eq("rst_energy", dut_stat(EI), 0);
        ack_seen = 0;
        repeat (5) cycle(8'h65, 8'h07);
        check_eq("rst_unarmed", ack_seen, 0);
        cycle(8'h00, 8'h07);
        cycle(8'h65, 8'h07);
        check_eq("rst_rearmed", int'(cmd_ack), 1);

        // Long random run with held bytes and occasional resets.
        cur_in = 8'h00;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 1999) == 0) do_reset(cur_in);
            if ($urandom_range(0, 3) == 0) begin
                pick = int'($urandom_range(0, 9));
                case (pick)
                    0, 1, 2, 3: cur_in = 8'h00;
                    4:          cur_in = 8'h65;
                    5:          cur_in = 8'h70;
                    6:          cur_in = 8'h62;
                    7:          cur_in = 8'h73;
                    8:          cur_in = 8'h77;
                    default:    cur_in = ($urandom_range(0, 1) == 0) ? 8'h72
                                                                     : 8'($urandom_range(0, 255));
                endcase
            end
            cycle(cur_in, 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
